// File: rtl/mem_word_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte memory.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_word_arbiter_if;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic [7:0]  d_rdata;
    logic [7:0]  mem_A;
    logic [7:0]  mem_WD;
    logic        mem_WE;
    logic [7:0]  mem_RD;
    logic        busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_A, mem_WD, mem_WE, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        output if_ack, if_rdata, d_ack, d_rdata, mem_A, mem_WD, mem_WE, busy
    );
endinterface

// File: rtl/mem_word_arbiter.sv
// Round-robin arbiter sharing one byte memory between a 4-beat word fetch port
// and a single-byte load/store port.
module mem_word_arbiter (
    input  logic            clock,
    input  logic            reset_n,
    mem_word_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DRD, DWR, ACK} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg;
    logic [7:0]  base_reg;
    logic [7:0]  addr_reg;
    logic [7:0]  wdata_reg;
    logic        grant_d_reg;
    logic        last_d_reg;
    logic [7:0]  d_rdata_reg;
    logic [7:0]  lane_reg [4];
    logic        any_req;
    logic        pick_d;

    assign any_req = bus.if_req | bus.d_req;
    // Data wins when alone, or on conflict when fetch was granted last.
    assign pick_d  = bus.d_req & (~bus.if_req | ~last_d_reg);

    always_ff @(posedge clock) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE: begin
                if (!any_req)    state_next = IDLE;
                else if (!pick_d) state_next = FETCH;
                else if (bus.d_we) state_next = DWR;
                else             state_next = DRD;
            end
            FETCH:   state_next = (cnt_reg == 2'd3) ? ACK : FETCH;
            DRD:     state_next = ACK;
            DWR:     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_reg     <= 2'd0;
            base_reg    <= 8'd0;
            addr_reg    <= 8'd0;
            wdata_reg   <= 8'd0;
            grant_d_reg <= 1'b0;
            last_d_reg  <= 1'b0;
            d_rdata_reg <= 8'd0;
        end else begin
            if (state_reg == IDLE && any_req) begin
                grant_d_reg <= pick_d;
                last_d_reg  <= pick_d;
                base_reg    <= bus.if_addr;
                addr_reg    <= bus.d_addr;
                wdata_reg   <= bus.d_wdata;
                cnt_reg     <= 2'd0;
            end
            if (state_reg == FETCH) cnt_reg <= cnt_reg + 2'd1;
            if (state_reg == DRD)   d_rdata_reg <= bus.mem_RD;
        end
    end

    // One register per byte lane so unfetched lanes hold until their beat.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clock) begin
                if (!reset_n)
                    lane_reg[gi] <= 8'd0;
                else if (state_reg == FETCH && cnt_reg == 2'(gi))
                    lane_reg[gi] <= bus.mem_RD;
            end
            assign bus.if_rdata[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign bus.d_rdata = d_rdata_reg;

    always_comb begin
        bus.mem_A  = 8'd0;
        bus.mem_WD = 8'd0;
        bus.mem_WE = 1'b0;
        bus.if_ack = 1'b0;
        bus.d_ack  = 1'b0;
        bus.busy   = (state_reg != IDLE);
        case (state_reg)
            FETCH: bus.mem_A = base_reg + {6'd0, cnt_reg};
            DRD:   bus.mem_A = addr_reg;
            DWR: begin
                bus.mem_A  = addr_reg;
                bus.mem_WD = wdata_reg;
                bus.mem_WE = 1'b1;
            end
            ACK: begin
                bus.if_ack = ~grant_d_reg;
                bus.d_ack  = grant_d_reg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_word_arbiter.sv
// Directed bench for mem_word_arbiter with a behavioural 256-byte memory.
module tb_mem_word_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    mem_word_arbiter_if bus();

    mem_word_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_RD = mem[bus.mem_A];
    always @(posedge clock) if (bus.mem_WE) mem[bus.mem_A] <= bus.mem_WD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_if_ack", 32'(bus.if_ack), 0);
        chk("rst_d_ack", 32'(bus.d_ack), 0);
        chk("rst_we", 32'(bus.mem_WE), 0);
        chk("rst_mem_a", 32'(bus.mem_A), 0);
        chk("rst_mem_wd", 32'(bus.mem_WD), 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", 32'(bus.d_rdata), 0);
        reset_n = 1'b1;
        $display("reset done");
    endtask

    // Word fetch; prev is the word held before this fetch, used for partial-lane checks.
    task automatic fetch_op(input logic [7:0] a, input logic [31:0] exp,
                            input logic [31:0] prev, input bit drop);
        logic [31:0] mask;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        cyc();
        for (int k = 0; k < 4; k++) begin
            mask = (k == 0) ? 32'h0 : (k == 1) ? 32'h000000FF :
                   (k == 2) ? 32'h0000FFFF : 32'h00FFFFFF;
            chk("f_mem_a", 32'(bus.mem_A), 32'(8'(a + 8'(k))));
            chk("f_we", 32'(bus.mem_WE), 0);
            chk("f_wd", 32'(bus.mem_WD), 0);
            chk("f_ack_early", 32'(bus.if_ack), 0);
            chk("f_partial", bus.if_rdata, (exp & mask) | (prev & ~mask));
            if (drop && k == 0) begin
                bus.if_req  = 1'b0;
                bus.if_addr = a ^ 8'h5A;
            end
            cyc();
        end
        chk("f_ack", 32'(bus.if_ack), 1);
        chk("f_d_ack", 32'(bus.d_ack), 0);
        chk("f_rdata", bus.if_rdata, exp);
        bus.if_req = 1'b0;
        cyc();
        chk("f_idle", 32'(bus.busy), 0);
        chk("f_ack_off", 32'(bus.if_ack), 0);
        $display("fetch addr=%0d word=%h", a, bus.if_rdata);
    endtask

    task automatic data_op(input bit we, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] exp);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        cyc();
        chk("d_mem_a", 32'(bus.mem_A), 32'(a));
        chk("d_we", 32'(bus.mem_WE), 32'(we));
        chk("d_wd", 32'(bus.mem_WD), we ? 32'(wd) : 0);
        chk("d_ack_early", 32'(bus.d_ack), 0);
        bus.d_addr  = a ^ 8'hFF;
        bus.d_wdata = ~wd;
        cyc();
        chk("d_ack", 32'(bus.d_ack), 1);
        chk("d_if_ack", 32'(bus.if_ack), 0);
        chk("d_we_off", 32'(bus.mem_WE), 0);
        if (!we) chk("d_rdata", 32'(bus.d_rdata), 32'(exp));
        else     chk("d_stored", 32'(mem[a]), 32'(wd));
        bus.d_req = 1'b0;
        cyc();
        chk("d_idle", 32'(bus.busy), 0);
        $display("%s addr=%0d data=%h", we ? "store" : "load", a, we ? wd : bus.d_rdata);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
        mem[100] = 8'h44; mem[101] = 8'h00; mem[102] = 8'h02; mem[103] = 8'h80;
        mem[68]  = 8'h05;
        mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        bus.if_req = 1'b0; bus.if_addr = 8'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'd0; bus.d_wdata = 8'd0;

        do_reset();
        fetch_op(8'd100, 32'h80020044, 32'h0, 1'b0);
        data_op(1'b0, 8'd68, 8'h00, 8'h05);
        data_op(1'b1, 8'd70, 8'hAA, 8'h00);
        data_op(1'b0, 8'd70, 8'h00, 8'hAA);
        fetch_op(8'd254, 32'h44332211, 32'h80020044, 1'b1);

        // Reset lands at the end of fetch beat 2.
        bus.if_req = 1'b1; bus.if_addr = 8'd100;
        cyc(); cyc(); cyc();
        chk("r_beat2_a", 32'(bus.mem_A), 102);
        reset_n = 1'b0;
        bus.if_req = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_if_ack", 32'(bus.if_ack), 0);
        chk("r_if_rdata", bus.if_rdata, 0);
        chk("r_mem_a", 32'(bus.mem_A), 0);
        cyc();
        chk("r_if_ack2", 32'(bus.if_ack), 0);
        $display("reset mid-fetch aborted");
        fetch_op(8'd100, 32'h80020044, 32'h0, 1'b0);

        // Both requesters held high from reset: grants go D,F,D,F.
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 8'd100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd68;
        cyc();
        for (int c = 1; c <= 17; c++) begin
            chk("arb_d_ack", 32'(bus.d_ack), (c == 2 || c == 11) ? 1 : 0);
            chk("arb_if_ack", 32'(bus.if_ack), (c == 8 || c == 17) ? 1 : 0);
            if (bus.d_ack)  $display("grant D ack cycle %0d rdata=%h", c, bus.d_rdata);
            if (bus.if_ack) $display("grant F ack cycle %0d word=%h", c, bus.if_rdata);
            if (c < 17) cyc();
        end
        chk("arb_rdata", bus.if_rdata, 32'h80020044);
        chk("arb_d_rdata", 32'(bus.d_rdata), 32'h05);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        cyc();
        chk("arb_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_word_arbiter.md
MEM_WORD_ARBITER -- requirements
Module: mem_word_arbiter

Interface
REQ-001 SHALL: clock  input  1  single system clock; all state updates on the rising edge.
REQ-002 SHALL: reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clock.
REQ-003 SHALL: if_req  input  1  instruction-fetch request; level, held until if_ack.
REQ-004 SHALL: if_addr  input  8  fetch base byte address.
REQ-005 SHALL: if_ack  output  1  one-cycle pulse; if_rdata valid.
REQ-006 SHALL: if_rdata  output  32  fetched instruction word, little-endian, registered, held until the next fetch completes.
REQ-007 SHALL: d_req  input  1  data request; level, held until d_ack.
REQ-008 SHALL: d_we  input  1  1 = byte store, 0 = byte load.
REQ-009 SHALL: d_addr  input  8  data byte address.
REQ-010 SHALL: d_wdata  input  8  store data.
REQ-011 SHALL: d_ack  output  1  one-cycle pulse; load data valid or store done.
REQ-012 SHALL: d_rdata  output  8  loaded byte, registered, held until the next load completes.
REQ-013 SHALL: mem_A  output  8  address to the byte memory.
REQ-014 SHALL: mem_WD  output  8  write data to the memory.
REQ-015 SHALL: mem_WE  output  1  memory write enable.
REQ-016 SHALL: mem_RD  input  8  combinational read data from the memory.
REQ-017 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL: FSM states are IDLE, FETCH, DRD, DWR and ACK; all other states are unreachable.
REQ-019 SHALL: IDLE samples the requests at the clock edge and latches the address, write data and grant; when no request is present it stays in IDLE.
REQ-020 SHALL: arbitration is round-robin on conflict: if both requests are present in IDLE, the requester not granted last wins; a single requester always wins.
REQ-021 SHALL: last_grant updates on every grant.
REQ-022 SHALL: a fetch grant enters FETCH with beat counter cnt=0.
REQ-023 SHALL: in FETCH, mem_A = base+cnt, modulo 256 (wrap 255->0).
REQ-024 SHALL: in FETCH, at each edge mem_RD is captured into if_rdata[8*cnt+7:8*cnt]; after cnt=3 the FSM goes to ACK.
REQ-025 SHALL: fetch latency is fixed: request sampled at the end of cycle 0, beats in cycles 1-4, if_ack in cycle 5.
REQ-026 SHALL: a data load enters DRD for one cycle: mem_A = d_addr, and mem_RD is captured into d_rdata at the edge; the FSM then goes to ACK, with d_ack in cycle 2.
REQ-027 SHALL: a data store enters DWR for exactly one cycle: mem_A = d_addr, mem_WD = d_wdata, mem_WE = 1; the FSM then goes to ACK, with d_ack in cycle 2.
REQ-028 SHALL: mem_WE is decoded from state only and is 1 solely in DWR.
REQ-029 SHALL: mem_A and mem_WD are stable for the whole DWR cycle.
REQ-030 SHALL: outside FETCH, DRD and DWR, mem_A = 0 and mem_WD = 0.
REQ-031 SHALL: ACK lasts one cycle and asserts only the granted requester's ack; requests are ignored in ACK; the FSM then returns to IDLE.
REQ-032 SHALL: a request still high in the cycle after ACK is treated as a new request; minimum spacing between grants is one IDLE cycle.
REQ-033 SHALL: request and address changes outside IDLE have no effect on the operation in progress.
REQ-034 SHALL: if_rdata bytes not yet fetched keep their previous value until the overwriting beat.

Reset
REQ-035 SHALL: when reset_n=0 at an edge: state goes to IDLE; cnt=0; last_grant=fetch, so data wins the first conflict; if_rdata=0; d_rdata=0; no ack is issued.
REQ-036 SHALL: reset_n=0 at an edge clears if_ack, d_ack, mem_WE, busy, mem_A and mem_WD to 0 from the following cycle.
REQ-037 SHALL: reset mid-operation aborts the operation with no ack; if it lands in DWR, that single write cycle has already occurred and is not repeated.

Verification
REQ-038 SHALL: memory bytes 100..103 = 44,00,02,80; if_req with if_addr=100 -> if_ack in cycle 5, if_rdata=32'h80020044, mem_WE=0 throughout.
REQ-039 SHALL: load d_addr=68 with mem[68]=5 -> d_ack in cycle 2, d_rdata=8'h05; then store 8'hAA to 70 -> mem_WE high exactly one cycle with mem_A=70; then load 70 -> 8'hAA.
REQ-040 SHALL: if_req and d_req both high after reset -> data served first, then fetch; with both re-requesting, grants alternate D,F,D,F.
REQ-041 SHALL: fetch with if_addr=254 -> beat addresses 254,255,0,1 in order.
REQ-042 SHALL: reset_n=0 during FETCH beat 2 -> next cycle IDLE, busy=0, no if_ack, if_rdata=0; a new fetch then completes normally.
REQ-043 SHALL: d_addr changed during DRD, or if_req dropped mid-FETCH -> the operation in progress completes with its latched values.
